// File: rtl/mem_pkg.sv
// Shared FSM state and default widths for the memory access pipe.
package mem_pkg;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_REG_W    = 3;
    localparam int DEF_LOAD_LAT = 2;
    localparam int CNT_W        = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        OUT_HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/data_memory_sp.sv
// Single-port data memory: synchronous write, registered read that only updates on a read enable.
module data_memory_sp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // rdata holds its value between reads so a stalled load bundle stays stable.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/memory_access_pipe.sv
// One-op-in-flight memory access stage: store/load/pass requests produce a write-back bundle.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module memory_access_pipe
    import mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int REG_W    = DEF_REG_W,
    parameter int LOAD_LAT = DEF_LOAD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic              in_wr_en,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_wr_en
);
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] data_r;
    logic [REG_W-1:0]  rd_r;
    logic              wr_en_r;
    logic              sel_mem;
    logic [DATA_W-1:0] mem_rdata;
    logic              accept;
    logic              op_store;
    logic              op_load;

    assign op_store = in_is_store;
    assign op_load  = in_is_load & ~in_is_store;
    assign in_ready = ~rst & ((state == IDLE) | ((state == OUT_HOLD) & wb_ready));
    assign accept   = in_valid & in_ready;

    data_memory_sp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (accept & op_store),
        .re    (accept & op_load),
        .addr  (in_addr),
        .wdata (in_data),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            data_r  <= '0;
            rd_r    <= '0;
            wr_en_r <= 1'b0;
            sel_mem <= 1'b0;
        end else begin
            case (state)
                LOAD_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= OUT_HOLD;
                end
                OUT_HOLD: if (wb_ready && !accept) state <= IDLE;
                default: ;
            endcase
            // A new accept overrides the drain above, giving back-to-back throughput.
            if (accept) begin
                rd_r    <= in_rd;
                wr_en_r <= in_wr_en;
                data_r  <= in_data;
                sel_mem <= op_load;
                if (op_load) begin
                    cnt   <= CNT_W'(LOAD_LAT - 1);
                    state <= (LOAD_LAT > 1) ? LOAD_WAIT : OUT_HOLD;
                end else begin
                    cnt   <= '0;
                    state <= OUT_HOLD;
                end
            end
        end
    end

    assign wb_valid = (state == OUT_HOLD);
    assign wb_data  = wb_valid ? (sel_mem ? mem_rdata : data_r) : '0;
    assign wb_rd    = wb_valid ? rd_r : '0;
    assign wb_wr_en = wb_valid & wr_en_r;
endmodule

// File: tb/tb_memory_access_pipe.sv
// Directed bench: three pipes (LOAD_LAT 1, 2, 8) share one request stream.
module tb_memory_access_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_addr;
    logic [15:0] in_data;
    logic [2:0]  in_rd;
    logic        in_is_load;
    logic        in_is_store;
    logic        in_wr_en;
    logic        wb_ready;

    logic        rdy1, v1, w1;
    logic [15:0] d1;
    logic [2:0]  r1;
    logic        rdy2, v2, w2;
    logic [15:0] d2;
    logic [2:0]  r2;
    logic        rdy8, v8, w8;
    logic [15:0] d8;
    logic [2:0]  r8;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    memory_access_pipe #(.LOAD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_addr(in_addr),
        .in_data(in_data), .in_rd(in_rd), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_wr_en(in_wr_en), .wb_valid(v1), .wb_ready(wb_ready), .wb_data(d1), .wb_rd(r1),
        .wb_wr_en(w1)
    );
    memory_access_pipe #(.LOAD_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_addr(in_addr),
        .in_data(in_data), .in_rd(in_rd), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_wr_en(in_wr_en), .wb_valid(v2), .wb_ready(wb_ready), .wb_data(d2), .wb_rd(r2),
        .wb_wr_en(w2)
    );
    memory_access_pipe #(.LOAD_LAT(8)) u_lat8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_addr(in_addr),
        .in_data(in_data), .in_rd(in_rd), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_wr_en(in_wr_en), .wb_valid(v8), .wb_ready(wb_ready), .wb_data(d8), .wb_rd(r8),
        .wb_wr_en(w8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [15:0] d,
                         input logic [2:0] r, input logic ld, input logic st, input logic we);
        in_valid    = v;
        in_addr     = a;
        in_data     = d;
        in_rd       = r;
        in_is_load  = ld;
        in_is_store = st;
        in_wr_en    = we;
    endtask

    task automatic idle_in();
        drive(1'b0, 5'd0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [15:0] pass_vals [4];

    initial begin
        pass_vals[0] = 16'd1;
        pass_vals[1] = 16'd2;
        pass_vals[2] = 16'd3;
        pass_vals[3] = 16'd4;
        rst      = 1'b1;
        wb_ready = 1'b1;
        idle_in();

        // Reset
        repeat (2) edge_();
        chk("rst_ready", 32'(rdy2), 32'd0);
        chk("rst_valid", 32'(v2), 32'd0);
        chk("rst_data", 32'(d2), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_ready", 32'(rdy2), 32'd1);

        // Store then load on the next cycle, all three latencies
        drive(1'b1, 5'd5, 16'h1234, 3'd0, 1'b0, 1'b1, 1'b0);
        edge_();
        chk("st_valid", 32'(v2), 32'd1);
        chk("st_data", 32'(d2), 32'h1234);
        chk("st_wren", 32'(w2), 32'd0);
        drive(1'b1, 5'd5, 16'h0, 3'd2, 1'b1, 1'b0, 1'b1);
        #1;
        chk("ld_ready1", 32'(rdy1), 32'd1);
        chk("ld_ready8", 32'(rdy8), 32'd1);
        edge_();
        idle_in();
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("lat1_valid_k%0d", k), 32'(v1), 32'(k == 1));
            chk($sformatf("lat2_valid_k%0d", k), 32'(v2), 32'(k == 2));
            chk($sformatf("lat8_valid_k%0d", k), 32'(v8), 32'(k == 8));
            if (k == 1) begin
                chk("lat1_data", 32'(d1), 32'h1234);
                chk("lat1_rd", 32'(r1), 32'd2);
            end
            if (k == 2) begin
                chk("lat2_data", 32'(d2), 32'h1234);
                chk("lat2_rd", 32'(r2), 32'd2);
                chk("lat2_wren", 32'(w2), 32'd1);
            end
            if (k == 8) begin
                chk("lat8_data", 32'(d8), 32'h1234);
                chk("lat8_rd", 32'(r8), 32'd2);
            end
            edge_();
        end

        // Four back-to-back pass ops
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd0, pass_vals[i], 3'(i), 1'b0, 1'b0, 1'b1);
            #1;
            chk($sformatf("b2b_ready_%0d", i), 32'(rdy2), 32'd1);
            edge_();
            chk($sformatf("b2b_valid_%0d", i), 32'(v2), 32'd1);
            chk($sformatf("b2b_data_%0d", i), 32'(d2), 32'(pass_vals[i]));
        end
        idle_in();
        edge_();
        chk("b2b_drain_valid", 32'(v2), 32'd0);
        chk("b2b_drain_data", 32'(d2), 32'd0);

        // Pass op stalled by wb_ready=0 for three cycles
        drive(1'b1, 5'd0, 16'hBEEF, 3'd3, 1'b0, 1'b0, 1'b1);
        edge_();
        wb_ready = 1'b0;
        drive(1'b1, 5'd0, 16'h5555, 3'd4, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall_ready_%0d", i), 32'(rdy2), 32'd0);
            chk($sformatf("stall_valid_%0d", i), 32'(v2), 32'd1);
            chk($sformatf("stall_data_%0d", i), 32'(d2), 32'hBEEF);
            chk($sformatf("stall_rd_%0d", i), 32'(r2), 32'd3);
            edge_();
        end
        wb_ready = 1'b1;
        #1;
        chk("release_ready", 32'(rdy2), 32'd1);
        edge_();
        chk("release_next_data", 32'(d2), 32'h5555);
        chk("release_next_rd", 32'(r2), 32'd4);
        idle_in();
        edge_();

        // Reset one cycle after a load accept
        drive(1'b1, 5'd5, 16'h0, 3'd1, 1'b1, 1'b0, 1'b1);
        edge_();
        idle_in();
        rst = 1'b1;
        #1;
        chk("ldrst_ready_in_rst", 32'(rdy2), 32'd0);
        edge_();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ldrst_no_valid_%0d", i), 32'(v2), 32'd0);
            edge_();
        end
        chk("ldrst_ready", 32'(rdy2), 32'd1);
        drive(1'b1, 5'd0, 16'h0042, 3'd6, 1'b0, 1'b0, 1'b1);
        edge_();
        chk("ldrst_pass_valid", 32'(v2), 32'd1);
        chk("ldrst_pass_data", 32'(d2), 32'h0042);
        idle_in();
        edge_();
        chk("ldrst_pass_done", 32'(v2), 32'd0);

        // Load+store flags together act as a store
        drive(1'b1, 5'd7, 16'h00AA, 3'd5, 1'b1, 1'b1, 1'b0);
        edge_();
        chk("both_valid1", 32'(v1), 32'd1);
        chk("both_valid8", 32'(v8), 32'd1);
        chk("both_data2", 32'(d2), 32'h00AA);
        chk("both_data8", 32'(d8), 32'h00AA);
        chk("both_wren", 32'(w2), 32'd0);
        chk("both_rd", 32'(r2), 32'd5);
        idle_in();
        edge_();
        drive(1'b1, 5'd7, 16'h0, 3'd6, 1'b1, 1'b0, 1'b1);
        edge_();
        idle_in();
        chk("ld7_not_yet", 32'(v2), 32'd0);
        edge_();
        chk("ld7_valid", 32'(v2), 32'd1);
        chk("ld7_data", 32'(d2), 32'h00AA);
        chk("ld7_wren", 32'(w2), 32'd1);
        repeat (8) edge_();

        // Address extremes with back-to-back stores
        drive(1'b1, 5'd31, 16'hFFFF, 3'd0, 1'b0, 1'b1, 1'b0);
        edge_();
        drive(1'b1, 5'd0, 16'h0001, 3'd0, 1'b0, 1'b1, 1'b0);
        edge_();
        drive(1'b1, 5'd31, 16'h0, 3'd7, 1'b1, 1'b0, 1'b1);
        edge_();
        idle_in();
        edge_();
        chk("ld31_data", 32'(d2), 32'hFFFF);
        chk("ld31_rd", 32'(r2), 32'd7);
        repeat (8) edge_();
        drive(1'b1, 5'd0, 16'h0, 3'd1, 1'b1, 1'b0, 1'b1);
        edge_();
        idle_in();
        chk("ld0_lat1_data", 32'(d1), 32'h0001);
        edge_();
        chk("ld0_data", 32'(d2), 32'h0001);
        repeat (8) edge_();
        chk("end_idle8", 32'(v8), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
